jtag_scan_sequencer: RTL and testbench
======================================

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 64, maximum scan length in bits.
REQ-002 Parameter LEN_W, default 7, width of the length field; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-003 Port TCK, input, 1, sole clock; state advances on rising edge; TMS/TDI launched on falling edge.
REQ-004 Port Reset, input, 1, asynchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, command offered.
REQ-006 Port cmd_ready, output, 1, sequencer accepts a command this cycle.
REQ-007 Port cmd_ir, input, 1, 1 = IR scan, 0 = DR scan.
REQ-008 Port cmd_len, input, LEN_W, number of bits to shift.
REQ-009 Port cmd_data, input, MAX_LEN, shift-in data, bit 0 shifted first.
REQ-010 Port rsp_valid, output, 1, result available.
REQ-011 Port rsp_ready, input, 1, result consumed.
REQ-012 Port rsp_data, output, MAX_LEN, captured TDO bits, bit i = i-th bit shifted out; bits >= len are 0.
REQ-013 Port rsp_err, output, 1, command rejected.
REQ-014 Port TMS, output, 1, to TAP controller.
REQ-015 Port TDI, output, 1, to TAP data/instruction path.
REQ-016 Port TDO, input, 1, from TAP; tri-state Z SHALL be captured as 0.

Function
REQ-017 States: TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP.
REQ-018 TLR_SEQ SHALL drive TMS=1 for 5 TCK cycles, then TMS=0 for 1 cycle, then enter IDLE (TAP in Run-Test/Idle).
REQ-019 cmd_ready SHALL be 1 only in IDLE; handshake completes on rising edge with cmd_valid & cmd_ready; the command is latched.
REQ-020 cmd_len = 0 or cmd_len > MAX_LEN SHALL go directly to RESP with rsp_err=1 and rsp_data=0; TMS held 0, no TAP movement.
REQ-021 DR scan TMS sequence: 1 (SEL_DR), 0 (CAPTURE), 0 (enter SHIFT), then len shift cycles.
REQ-022 IR scan TMS sequence: 1 (SEL_DR), 1 (SEL_IR), 0 (CAPTURE), 0 (enter SHIFT), then len shift cycles.
REQ-023 In SHIFT, TDI SHALL present data bit i during shift cycle i; TMS=0 for cycles 0..len-2 and TMS=1 on cycle len-1 (enters EXIT1).
REQ-024 TDO SHALL be sampled on the rising edge ending each shift cycle and stored at rsp_data[i].
REQ-025 EXIT1 SHALL drive TMS=1 (to UPDATE); UPDATE SHALL drive TMS=0 (to Run-Test/Idle), then enter RESP.
REQ-026 RESP SHALL hold rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready=1, then return to IDLE; TMS=0 throughout (TAP parks in Run-Test/Idle).
REQ-027 Shift counter SHALL be LEN_W bits, count 0..len-1, and never wrap within a command.
REQ-028 TDI SHALL be 0 outside SHIFT.
REQ-029 Scan latency from accept to rsp_valid: DR = len+5 cycles, IR = len+6 cycles.

Reset
REQ-030 Reset asserted at any time, including mid-SHIFT, SHALL immediately force TLR_SEQ, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0; the in-flight command is discarded without a response.
REQ-031 After Reset deasserts, the REQ-018 sequence SHALL complete before cmd_ready rises.

Configuration
REQ-032 Macro JTAG_SEQ_RUNTEST_EN defined: adds input cmd_idle (8 bits, latched with the command); after UPDATE the sequencer SHALL remain in Run-Test/Idle with TMS=0 for cmd_idle extra cycles before RESP. Undefined: no port, zero extra cycles.

Verification
REQ-033 Reset release -> TMS = 1,1,1,1,1,0; cmd_ready=1 on 7th cycle.
REQ-034 IR scan, len=2, data=2'b01 -> TMS 1,1,0,0,0,1,1,0; TDI bits 1,0; rsp_data[1:0] = TAP IR capture value; rsp_valid at cycle 8.
REQ-035 DR scan, len=1, data=1, TAP in BYPASS -> rsp_data[0]=0 (bypass capture); a following len=2 scan of 2'b11 returns 2'b10.
REQ-036 DR scan, len=51, walking-one data, boundary chain selected -> captured pins in bits 0..50, bits 51..63 = 0.
REQ-037 cmd_len=0 and cmd_len=65 -> rsp_err=1 next cycle, TMS stays 0; rsp_ready held 0 for 10 cycles -> rsp_valid and data stable.
REQ-038 Reset pulsed at shift cycle 20 of a 51-bit scan -> no response, TLR sequence restarts, next scan returns correct data.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: walks a TAP through Test-Logic-Reset, IR/DR scans and returns captured TDO.
// Build option JTAG_SEQ_RUNTEST_EN adds cmd_idle, extra Run-Test/Idle cycles before each response.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               TCK,
    input  logic               Reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SEQ_RUNTEST_EN
    input  logic [7:0]         cmd_idle,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    typedef enum logic [3:0] {
        TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic               ir_q;
    logic               cap2_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               rsp_err_q;
    logic               rsp_valid_q;
    logic               ready_q;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               tdo_bit;
    logic               last_shift;
    logic               bad_len;
`ifdef JTAG_SEQ_RUNTEST_EN
    logic [7:0]         idle_q, idle_cnt_q;
`endif

    // A floating TDO reads as 0.
    assign tdo_bit    = (TDO === 1'b1);
    assign last_shift = (cnt_q == len_q - LEN_W'(1));
    assign bad_len    = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));

    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            state_q     <= TLR_SEQ;
            cnt_q       <= '0;
            len_q       <= '0;
            ir_q        <= 1'b0;
            cap2_q      <= 1'b0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
`ifdef JTAG_SEQ_RUNTEST_EN
            idle_q      <= '0;
            idle_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                TLR_SEQ: begin
                    if (cnt_q == LEN_W'(5)) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        len_q      <= cmd_len;
                        ir_q       <= cmd_ir;
                        data_q     <= cmd_data;
                        rsp_data_q <= '0;
                        cnt_q      <= '0;
                        cap2_q     <= 1'b0;
`ifdef JTAG_SEQ_RUNTEST_EN
                        idle_q     <= cmd_idle;
                        idle_cnt_q <= '0;
`endif
                        if (bad_len) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            rsp_err_q <= 1'b0;
                            state_q   <= SEL_DR;
                        end
                    end
                end
                SEL_DR:  state_q <= ir_q ? SEL_IR : CAPTURE;
                SEL_IR:  state_q <= CAPTURE;
                // Two TMS=0 cycles: Select->Capture, then Capture->Shift.
                CAPTURE: begin
                    cap2_q <= ~cap2_q;
                    if (cap2_q) state_q <= SHIFT;
                end
                SHIFT: begin
                    rsp_data_q <= rsp_data_q | ({{(MAX_LEN-1){1'b0}}, tdo_bit} << cnt_q);
                    data_q     <= data_q >> 1;
                    if (last_shift) begin
                        cnt_q   <= '0;
                        state_q <= EXIT1;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                EXIT1:   state_q <= UPDATE;
                UPDATE: begin
`ifdef JTAG_SEQ_RUNTEST_EN
                    if (idle_cnt_q != idle_q) begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`else
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= TLR_SEQ;
            endcase
        end
    end

    always_comb begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        case (state_q)
            TLR_SEQ: tms_d = (cnt_q != LEN_W'(5));
            SEL_DR:  tms_d = 1'b1;
            SEL_IR:  tms_d = 1'b1;
            SHIFT: begin
                tms_d = last_shift;
                tdi_d = data_q[0];
            end
            EXIT1:   tms_d = 1'b1;
            default: tms_d = 1'b0;
        endcase
    end

    // TAP samples on the rising edge, so launch TMS/TDI half a cycle earlier.
    always_ff @(negedge TCK or posedge Reset) begin
        if (Reset) begin
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
        end else begin
            tms_q <= tms_d;
            tdi_q <= tdi_d;
        end
    end

    assign TMS       = tms_q;
    assign TDI       = tdi_q;
    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer against a behavioural 16-state TAP with 2-bit IR,
// a 1-bit bypass register and a 51-bit boundary chain.
module tb_jtag_scan_sequencer;

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR,
        T_UDR, T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_t;

    localparam logic [1:0]  IR_BYP = 2'b01;
    localparam logic [1:0]  IR_BSR = 2'b10;
    localparam logic [50:0] PINS   = 51'h5_A5C3_0F96_1E2D;

    logic        TCK = 1'b0;
    logic        Reset;
    logic        cmd_valid, cmd_ready, cmd_ir;
    logic [6:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_data;
    logic        TMS, TDI, TDO;

    int ntests = 0;
    int nfail  = 0;
    logic tms_log[$];
    logic tdi_log[$];

    jtag_scan_sequencer #(.MAX_LEN(64), .LEN_W(7)) dut (
        .TCK(TCK), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 TCK = ~TCK;

    always @(posedge TCK) begin
        tms_log.push_back(TMS);
        tdi_log.push_back(TDI);
    end

    // Behavioural TAP
    tap_t        ts = T_PDR;
    logic [1:0]  ir = IR_BYP;
    logic [1:0]  ir_sr = 2'b00;
    logic [50:0] bsr_sr = '0;
    logic [50:0] bsr_upd = '0;
    logic        byp = 1'b0;
    logic        tdo_r = 1'b0;

    function automatic tap_t nxt(input tap_t s, input logic m);
        case (s)
            T_TLR:  return m ? T_TLR  : T_RTI;
            T_RTI:  return m ? T_SDR  : T_RTI;
            T_SDR:  return m ? T_SIR  : T_CDR;
            T_CDR:  return m ? T_E1DR : T_SHDR;
            T_SHDR: return m ? T_E1DR : T_SHDR;
            T_E1DR: return m ? T_UDR  : T_PDR;
            T_PDR:  return m ? T_E2DR : T_PDR;
            T_E2DR: return m ? T_UDR  : T_SHDR;
            T_UDR:  return m ? T_SDR  : T_RTI;
            T_SIR:  return m ? T_TLR  : T_CIR;
            T_CIR:  return m ? T_E1IR : T_SHIR;
            T_SHIR: return m ? T_E1IR : T_SHIR;
            T_E1IR: return m ? T_UIR  : T_PIR;
            T_PIR:  return m ? T_E2IR : T_PIR;
            T_E2IR: return m ? T_UIR  : T_SHIR;
            default: return m ? T_SDR : T_RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (ts)
            T_TLR:  ir <= IR_BYP;
            T_CDR:  if (ir == IR_BSR) bsr_sr <= PINS; else byp <= 1'b0;
            T_SHDR: if (ir == IR_BSR) bsr_sr <= {TDI, bsr_sr[50:1]}; else byp <= TDI;
            T_UDR:  if (ir == IR_BSR) bsr_upd <= bsr_sr;
            T_CIR:  ir_sr <= 2'b01;
            T_SHIR: ir_sr <= {TDI, ir_sr[1]};
            T_UIR:  ir <= ir_sr;
            default: ;
        endcase
        ts <= nxt(ts, TMS);
    end

    always @(negedge TCK) begin
        if (ts == T_SHDR)      tdo_r <= (ir == IR_BSR) ? bsr_sr[0] : byp;
        else if (ts == T_SHIR) tdo_r <= ir_sr[0];
        else                   tdo_r <= 1'bz;
    end
    assign TDO = tdo_r;

    function automatic logic [15:0] pack(input logic q[$]);
        logic [15:0] v = '0;
        foreach (q[i]) if (i < 16) v = {v[14:0], q[i]};
        return v;
    endfunction

    function automatic int ones(input logic q[$]);
        int c = 0;
        foreach (q[i]) if (q[i]) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ir_i, input logic [6:0] len, input logic [63:0] data);
        int n = 0;
        @(negedge TCK);
        while (!cmd_ready && n < 200) begin
            @(negedge TCK);
            n++;
        end
        chk("issue_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_ir    = ir_i;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge TCK);
        #1;
        tms_log.delete();
        tdi_log.delete();
        @(negedge TCK);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(output int lat);
        int n = 0;
        lat = -1;
        while (n < 300) begin
            @(negedge TCK);
            if (rsp_valid) begin
                lat = tms_log.size();
                break;
            end
            n++;
        end
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        @(posedge TCK);
        #1 rsp_ready = 1'b0;
        @(negedge TCK);
        chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("ready_back", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic scan(input string tag, input logic ir_i, input logic [6:0] len,
                        input logic [63:0] data, input int exp_lat, input logic [63:0] exp_data);
        int lat;
        issue(ir_i, len, data);
        collect(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, {63'd0, rsp_err}, 64'd0);
    endtask

    task automatic tlr_check(input string tag);
        logic [5:0] rdy = '0;
        @(negedge TCK);
        Reset = 1'b0;
        tms_log.delete();
        tdi_log.delete();
        for (int k = 0; k < 6; k++) begin
            @(posedge TCK);
            @(negedge TCK);
            rdy = {rdy[4:0], cmd_ready};
        end
        chk({tag, "_tms"}, 64'(pack(tms_log)), 64'b111110);
        chk({tag, "_ready"}, 64'(rdy), 64'b000001);
        chk({tag, "_tdi"}, 64'(ones(tdi_log)), 64'd0);
        chk({tag, "_tap_rti"}, 64'(ts), 64'(T_RTI));
        chk({tag, "_tap_ir"}, 64'(ir), 64'(IR_BYP));
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_tms"}, {63'd0, TMS}, 64'd1);
        chk({tag, "_tdi"}, {63'd0, TDI}, 64'd0);
        chk({tag, "_ready"}, {63'd0, cmd_ready}, 64'd0);
        chk({tag, "_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_err"}, {63'd0, rsp_err}, 64'd0);
        chk({tag, "_data"}, rsp_data, 64'd0);
    endtask

    task automatic err_case(input string tag, input logic [6:0] len);
        int lat;
        logic ok = 1'b1;
        logic [63:0] d0;
        issue(1'b0, len, 64'hFFFF_0000_FFFF_0000);
        collect(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd1);
        chk({tag, "_err"}, {63'd0, rsp_err}, 64'd1);
        chk({tag, "_data"}, rsp_data, 64'd0);
        d0 = rsp_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge TCK);
            if (!rsp_valid || !rsp_err || rsp_data !== d0) ok = 1'b0;
        end
        chk({tag, "_hold"}, {63'd0, ok}, 64'd1);
        chk({tag, "_tms"}, 64'(ones(tms_log)), 64'd0);
        chk({tag, "_tdi"}, 64'(ones(tdi_log)), 64'd0);
        chk({tag, "_tap_rti"}, 64'(ts), 64'(T_RTI));
        consume();
    endtask

    initial begin
        logic [63:0] d;
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir    = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge TCK);
        reset_outputs("por");
        tlr_check("por_tlr");

        // IR scan of 2'b01 selects BYPASS; IR capture pattern is 2'b01
        scan("ir_byp", 1'b1, 7'd2, 64'h1, 8, 64'h1);
        chk("ir_byp_tms", 64'(pack(tms_log)), 64'b11000110);
        chk("ir_byp_tdi", 64'(pack(tdi_log)), 64'b00001000);
        consume();
        chk("ir_byp_tap_ir", 64'(ir), 64'(IR_BYP));
        chk("ir_byp_tap_rti", 64'(ts), 64'(T_RTI));

        scan("dr_byp1", 1'b0, 7'd1, 64'h1, 6, 64'h0);
        chk("dr_byp1_tms", 64'(pack(tms_log)), 64'b100110);
        consume();
        scan("dr_byp2", 1'b0, 7'd2, 64'h3, 7, 64'h2);
        chk("dr_byp2_tms", 64'(pack(tms_log)), 64'b1000110);
        chk("dr_byp2_tdi", 64'(pack(tdi_log)), 64'b0001100);
        consume();

        scan("ir_bsr", 1'b1, 7'd2, 64'h2, 8, 64'h1);
        consume();
        chk("ir_bsr_tap_ir", 64'(ir), 64'(IR_BSR));

        scan("bsr_w17", 1'b0, 7'd51, 64'hFFF8_0000_0002_0000, 56, {13'd0, PINS});
        chk("bsr_w17_hi", 64'(rsp_data[63:51]), 64'd0);
        consume();
        chk("bsr_w17_upd", 64'(bsr_upd), 64'h2_0000);
        scan("bsr_w50", 1'b0, 7'd51, 64'h0004_0000_0000_0000, 56, {13'd0, PINS});
        consume();
        chk("bsr_w50_upd", 64'(bsr_upd), 64'h0004_0000_0000_0000);

        d = 64'h0123_4567_89AB_CDEF;
        scan("dr_max", 1'b0, 7'd64, d, 69, {d[12:0], PINS});
        consume();

        err_case("len0", 7'd0);
        err_case("len65", 7'd65);

        // Reset during shift cycle 20 of a 51-bit boundary scan
        issue(1'b0, 7'd51, 64'h1);
        repeat (23) @(posedge TCK);
        #2 Reset = 1'b1;
        #1 reset_outputs("mid_rst");
        begin
            logic seen = 1'b0;
            repeat (3) begin
                @(negedge TCK);
                if (rsp_valid) seen = 1'b1;
            end
            chk("mid_rst_norsp", {63'd0, seen}, 64'd0);
        end
        tlr_check("mid_tlr");
        scan("mid_ir", 1'b1, 7'd2, 64'h2, 8, 64'h1);
        consume();
        scan("mid_bsr", 1'b0, 7'd51, 64'h100, 56, {13'd0, PINS});
        consume();
        chk("mid_bsr_upd", 64'(bsr_upd), 64'h100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
